// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU; single-cycle ops plus bit-serial SLL, with
//            valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module alu_exec_unit #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    alu_ctr,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  input  logic [SW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          zero,
  output logic          ovf
);

  localparam logic [1:0]    C_IDLE    = 2'd0;
  localparam logic [1:0]    C_SHIFT   = 2'd1;
  localparam logic [1:0]    C_DONE    = 2'd2;
  localparam logic [SW-1:0] C_CNT_ONE = SW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [W-1:0]  r_work;
  logic [SW-1:0] r_cnt;

  logic          w_accept;
  logic          w_is_shift;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_alu_res;
  logic          w_alu_ovf;
  logic [W-1:0]  w_shift_next;

  assign w_accept     = in_valid && in_ready && !flush;
  assign w_is_shift   = (alu_ctr == 3'b101) && (shamt != '0);
  assign w_sum        = op_a + op_b;
  assign w_diff       = op_a - op_b;
  assign w_shift_next = {r_work[W-2:0], 1'b0};

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_ctr)
      3'b000: w_alu_res = op_a & op_b;
      3'b001: w_alu_res = op_a | op_b;
      3'b010: begin
        w_alu_res = w_sum;
        w_alu_ovf = (op_a[W-1] == op_b[W-1]) && (w_sum[W-1] != op_a[W-1]);
      end
      3'b011: w_alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b100: w_alu_res = w_sum;
      // Only the shamt==0 case completes here; nonzero shifts go serial.
      3'b101: w_alu_res = op_b;
      3'b110: begin
        w_alu_res = w_diff;
        w_alu_ovf = (op_a[W-1] != op_b[W-1]) && (w_diff[W-1] != op_a[W-1]);
      end
      default: w_alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = C_IDLE;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_accept) w_next = w_is_shift ? C_SHIFT : C_DONE;
        end
        C_SHIFT: begin
          if (r_cnt == C_CNT_ONE) w_next = C_DONE;
        end
        C_DONE: begin
          if (w_accept)       w_next = w_is_shift ? C_SHIFT : C_DONE;
          else if (out_ready) w_next = C_IDLE;
        end
        default: w_next = C_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == C_IDLE) || ((r_state == C_DONE) && out_ready);
    out_valid = (r_state == C_DONE);
  end

  // Result/flags only change when an op completes, so they hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      r_work <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_is_shift) begin
        r_work <= op_b;
        r_cnt  <= shamt;
      end else begin
        result <= w_alu_res;
        zero   <= (w_alu_res == '0);
        ovf    <= w_alu_ovf;
      end
    end else if (r_state == C_SHIFT) begin
      r_work <= w_shift_next;
      r_cnt  <= r_cnt - C_CNT_ONE;
      if (r_cnt == C_CNT_ONE) begin
        result <= w_shift_next;
        zero   <= (w_shift_next == '0);
        ovf    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 3-bit `ALUCtr` code from the ALU control unit, together with the operand pair and shift amount, and produces a registered result, a zero flag and a signed-overflow flag. It sits between the register-read stage and memory/write-back. All operations complete in one cycle except SLL, which shifts one bit per cycle. Valid/ready handshakes on both sides let the result hold under back-pressure.

## Interface
- `W`, 32, operand and result width.
- `SW`, 5, shift-amount width; must satisfy 2^SW = W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous pipeline flush that drops the in-flight operation.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request this cycle.
- `alu_ctr` in 3: operation code from the ALU control unit.
- `op_a` in W: rs operand.
- `op_b` in W: rt operand, or the immediate.
- `shamt` in SW: shift amount, used by SLL only.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out W: registered result.
- `zero` out 1: result == 0.
- `ovf` out 1: signed overflow for codes 010 and 110.

## Operation
- Codes:
  - 000 AND: a&b.
  - 001 OR: a|b.
  - 010 ADD: a+b, signed.
  - 011 SLT: signed a<b gives 1, otherwise 0.
  - 100 ADDU: a+b.
  - 101 SLL: b<<shamt.
  - 110 SUB: a−b (covers sub, subu, beq).
  - 111 SLTU: unsigned a<b gives 1, otherwise 0.
- Arithmetic wraps modulo 2^W. SLT and SLTU results are zero-extended to W.
- `ovf` is set only for 010 and 110, from the operand and result sign bits. It is 0 for all other codes. The consumer decides whether to trap.
- `zero` is computed from the final registered `result`.
- States:
  - IDLE: no operation held.
  - SHIFT: iterative SLL in progress.
  - DONE: result held, `out_valid`=1.
- A transfer occurs when `in_valid && in_ready`. `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- On acceptance, for any code other than 101, or 101 with shamt==0:
  - compute the result;
  - go to DONE.
- On acceptance of 101 with shamt>0:
  - load the working register with b and the counter with shamt;
  - go to SHIFT.
- In SHIFT, each cycle shifts the working register left 1 and decrements the counter. When the counter goes 1→0, go to DONE.
- In DONE with `out_ready`=1, the result is consumed:
  - if a new request is accepted the same cycle, start it (back-to-back, no bubble);
  - otherwise go to IDLE.
- In DONE with `out_ready`=0, `result`, `zero` and `ovf` hold stable.
- Operand inputs are sampled only on the acceptance edge. Changes during SHIFT have no effect.
- `flush`=1 has priority over every transition:
  - next state is IDLE, `out_valid` goes to 0;
  - the counter is cleared, and any request presented that cycle is not accepted;
  - `in_ready` still reads its combinational value, but the transfer is suppressed.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `out_valid`=0, `result`=0, `zero`=0, `ovf`=0, counter=0.
  - No transfer occurs while `rst_n`=0.
  - If reset is asserted mid-SHIFT or in DONE, the operation is discarded.
- Latency, from acceptance edge to `out_valid` high:
  - 1 cycle for non-shift ops and SLL with shamt=0;
  - shamt cycles for SLL with shamt≥1.
- Maximum SLL latency is W−1 cycles. `in_ready`=0 throughout SHIFT.
- Throughput is one op per cycle for non-shift ops when `out_ready` is held high.
- `out_valid` drops the cycle after consumption unless a new op was accepted on the same edge with latency 1.

## Test plan
- ADD and overflow:
  - op_a=0x7FFFFFFF, op_b=1, code 010 → next cycle result=0x80000000, ovf=1, zero=0.
  - Same operands with code 100 → ovf=0.
- SUB and zero: op_a=op_b=0x1234, code 110 → result=0, zero=1, ovf=0. Then op_a=0x80000000, op_b=1 → result=0x7FFFFFFF, ovf=1.
- Set-less-than: op_a=0xFFFFFFFF, op_b=1 → code 011 gives result=1; code 111 gives result=0.
- Shift:
  - op_b=0x3, shamt=4, code 101 → in_ready low for 4 cycles, result=0x30 at cycle 4.
  - shamt=0 → result=0x3 after 1 cycle.
  - shamt=31, op_b=1 → result=0x80000000 after 31 cycles.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 3 cycles after an AND (0xF0F0 & 0xFF00 = 0xF000) → result stable, in_ready=0.
  - Raise out_ready with an OR pending → OR result the next cycle, no bubble.
- Flush and reset:
  - Assert flush in the 2nd cycle of a shamt=10 SLL → IDLE next cycle, out_valid never rises.
  - Assert rst_n=0 while in DONE → out_valid and result go to 0 immediately.
